// File: rtl/gcd_stein_unit_pkg.sv
// Shared types for the binary (Stein) GCD unit: FSM states and the
// CALC step-select code passed from control to datapath.
package gcd_pkg;

    typedef enum logic [1:0] {
        GCD_IDLE = 2'd0,
        GCD_CALC = 2'd1,
        GCD_DONE = 2'd2
    } gcd_state_e;

    typedef enum logic [2:0] {
        ZERO_A,
        ZERO_B,
        SHIFT_BOTH,
        SHIFT_A,
        SHIFT_B,
        SUB_A,
        SUB_B
    } gcd_step_e;

    // Priority decode of one Stein step; the first matching rule wins, and
    // the A>=B test on odd operands keeps the subtraction from underflowing.
    function automatic gcd_step_e select_step(input logic a_zero,
                                              input logic b_zero,
                                              input logic a_odd,
                                              input logic b_odd,
                                              input logic a_ge_b);
        if (a_zero)                 return ZERO_A;
        else if (b_zero)            return ZERO_B;
        else if (!a_odd && !b_odd)  return SHIFT_BOTH;
        else if (!a_odd)            return SHIFT_A;
        else if (!b_odd)            return SHIFT_B;
        else if (a_ge_b)            return SUB_A;
        else                        return SUB_B;
    endfunction

endpackage

// File: rtl/gcd_stein_unit_if.sv
// Operand/result val-rdy handshake bundle of the GCD unit.
interface gcd_stein_unit_if #(
    parameter int unsigned W = 16
);
    logic         operands_val;
    logic         operands_rdy;
    logic [W-1:0] operands_bits_A;
    logic [W-1:0] operands_bits_B;
    logic         result_val;
    logic         result_rdy;
    logic [W-1:0] result_bits_data;

    // Request source / result consumer side.
    modport master (
        output operands_val, operands_bits_A, operands_bits_B, result_rdy,
        input  operands_rdy, result_val, result_bits_data
    );

    // GCD unit side.
    modport slave (
        input  operands_val, operands_bits_A, operands_bits_B, result_rdy,
        output operands_rdy, result_val, result_bits_data
    );
endinterface

// File: rtl/gcd_stein_datapath.sv
// Stein GCD datapath: operand registers, power-of-two counter k, result
// register, plus the shift/subtract/compare logic and status bits.
module gcd_stein_datapath
    import gcd_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned KW = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_step_en,
    input  gcd_step_e    i_step,
    output logic         o_a_zero,
    output logic         o_b_zero,
    output logic         o_a_odd,
    output logic         o_b_odd,
    output logic         o_a_ge_b,
    output logic [W-1:0] o_res
);

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_res;
    logic [W-1:0]  w_diff_ab;
    logic [W-1:0]  w_diff_ba;

    assign w_diff_ab = r_a - r_b;
    assign w_diff_ba = r_b - r_a;

    assign o_a_zero = (r_a == '0);
    assign o_b_zero = (r_b == '0);
    assign o_a_odd  = r_a[0];
    assign o_b_odd  = r_b[0];
    assign o_a_ge_b = (r_a >= r_b);
    assign o_res    = r_res;

    // Load operands on accept, otherwise apply one selected step per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_k   <= '0;
            r_res <= '0;
        end else if (i_load) begin
            r_a <= i_a;
            r_b <= i_b;
            r_k <= '0;
        end else if (i_step_en) begin
            case (i_step)
                ZERO_A:     r_res <= r_b << r_k;
                ZERO_B:     r_res <= r_a << r_k;
                SHIFT_BOTH: begin
                    r_a <= r_a >> 1;
                    r_b <= r_b >> 1;
                    r_k <= r_k + 1'b1;
                end
                SHIFT_A:    r_a <= r_a >> 1;
                SHIFT_B:    r_b <= r_b >> 1;
                SUB_A:      r_a <= w_diff_ab >> 1;
                SUB_B:      r_b <= w_diff_ba >> 1;
                default:    r_res <= r_res;
            endcase
        end
    end

endmodule

// File: rtl/gcd_stein_unit.sv
// Binary GCD unit: IDLE/CALC/DONE control FSM with val/rdy handshakes
// around the Stein datapath.
module gcd_stein_unit
    import gcd_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    gcd_stein_unit_if.slave   io
);

    localparam int unsigned KW = $clog2(W + 1);

    gcd_state_e r_state;
    logic       r_operands_rdy;
    logic       r_result_val;
    gcd_step_e  w_step;
    logic       w_load;
    logic       w_step_en;
    logic       w_a_zero;
    logic       w_b_zero;
    logic       w_a_odd;
    logic       w_b_odd;
    logic       w_a_ge_b;
    logic [W-1:0] w_res;

    assign w_load    = (r_state == GCD_IDLE) && io.operands_val;
    assign w_step_en = (r_state == GCD_CALC);

    // Select the Stein step from the current datapath status.
    always_comb begin
        w_step = select_step(w_a_zero, w_b_zero, w_a_odd, w_b_odd, w_a_ge_b);
    end

    // Control FSM; rdy/val are registered alongside the state so they
    // always equal (state==IDLE) and (state==DONE).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= GCD_IDLE;
            r_operands_rdy <= 1'b1;
            r_result_val   <= 1'b0;
        end else begin
            case (r_state)
                GCD_IDLE: begin
                    if (io.operands_val) begin
                        r_state        <= GCD_CALC;
                        r_operands_rdy <= 1'b0;
                    end
                end
                GCD_CALC: begin
                    if (w_step == ZERO_A || w_step == ZERO_B) begin
                        r_state      <= GCD_DONE;
                        r_result_val <= 1'b1;
                    end
                end
                GCD_DONE: begin
                    if (io.result_rdy) begin
                        r_state        <= GCD_IDLE;
                        r_result_val   <= 1'b0;
                        r_operands_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state        <= GCD_IDLE;
                    r_operands_rdy <= 1'b1;
                    r_result_val   <= 1'b0;
                end
            endcase
        end
    end

    assign io.operands_rdy     = r_operands_rdy;
    assign io.result_val       = r_result_val;
    assign io.result_bits_data = w_res;

    gcd_stein_datapath #(
        .W  (W),
        .KW (KW)
    ) u_dp (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_load),
        .i_a       (io.operands_bits_A),
        .i_b       (io.operands_bits_B),
        .i_step_en (w_step_en),
        .i_step    (w_step),
        .o_a_zero  (w_a_zero),
        .o_b_zero  (w_b_zero),
        .o_a_odd   (w_a_odd),
        .o_b_odd   (w_b_odd),
        .o_a_ge_b  (w_a_ge_b),
        .o_res     (w_res)
    );

endmodule
